// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Brief    : 16x-oversampling UART receiver, 8 data bits LSB first, odd parity,
//            one stop bit, valid/ack handshake with sticky overrun.
// Revision : 1.0
// ============================================================================
module serial_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_COMPLETE = 3'd5,
        S_BREAK    = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_os_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_par_err;
    logic            r_stop_bit;

    logic            w_tick;
    logic            w_start_edge;
    logic            w_mid_start;
    logic            w_mid_bit;

    assign w_tick       = (r_tick_cnt == TW'(DIV - 1));
    assign w_start_edge = (r_state == S_IDLE) && r_prev && !r_sync2;
    assign w_mid_start  = w_tick && (r_os_cnt == 4'd7);
    assign w_mid_bit    = w_tick && (r_os_cnt == 4'd15);
    assign rx_busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start_edge) w_next = S_START;
            S_START:    if (w_mid_start)  w_next = r_sync2 ? S_IDLE : S_DATA;
            S_DATA:     if (w_mid_bit && (r_bit_idx == 3'd7)) w_next = S_PARITY;
            S_PARITY:   if (w_mid_bit)    w_next = S_STOP;
            S_STOP:     if (w_mid_bit)    w_next = S_COMPLETE;
            S_COMPLETE: w_next = r_stop_bit ? S_IDLE : S_BREAK;
            S_BREAK:    if (r_sync2)      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Sampling datapath: synchronizer, tick/oversample timing and bit capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_tick_cnt <= '0;
            r_os_cnt   <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_par_err  <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_start_edge || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end

            if (w_start_edge || ((r_state == S_START) && w_mid_start)) begin
                r_os_cnt <= 4'd0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + 4'd1;
            end

            if ((r_state == S_START) && w_mid_start) begin
                r_bit_idx <= 3'd0;
            end
            if ((r_state == S_DATA) && w_mid_bit) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if ((r_state == S_PARITY) && w_mid_bit) begin
                r_par_err <= (r_sync2 != ~^r_shift);
            end
            if ((r_state == S_STOP) && w_mid_bit) begin
                r_stop_bit <= r_sync2;
            end
        end
    end

    // A completing frame takes priority over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= 8'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (r_state == S_COMPLETE) begin
            data       <= r_shift;
            parity_err <= r_par_err;
            frame_err  <= !r_stop_bit;
            rx_valid   <= 1'b1;
            if (rx_valid) begin
                overrun <= !rx_ack;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
